// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller.
package fetch_ctrl_pkg;

  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    INSTR_CONTINUE = 2'd0,
    INSTR_MAINTAIN = 2'd1
  } instr_FETCH_t;

  typedef enum logic [1:0] {
    FC_REQ   = 2'd0,
    FC_VALID = 2'd1,
    FC_DRAIN = 2'd2
  } fetch_ctrl_state_t;

  localparam u64          PCINIT      = 64'h0000_0000_8000_0000;
  localparam int unsigned PC_STEP_DEF = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// PC sequencer and single-outstanding I-bus handshake controller feeding the fetch stage.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter u64          RESET_PC = PCINIT,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic         ireq_valid,
  output logic [63:0]  ireq_addr,
  input  logic         iresp_data_ok,
  input  logic [31:0]  iresp_data,
  output logic [31:0]  raw_instr,
  output logic [63:0]  pc,
  output logic         ivalid,
  output instr_FETCH_t instr_fetch,
  output logic         iwait,
  output logic         misalign
);

  fetch_ctrl_state_t state_q, state_d;
  u64   pc_q, pc_d;
  u64   pend_pc_q, pend_pc_d;
  u64   out_pc_q, out_pc_d;
  u32   raw_q, raw_d;
  logic misalign_q, misalign_d;
  logic pc_misaligned;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FC_REQ;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 64'd0;
      out_pc_q   <= 64'd0;
      raw_q      <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      out_pc_q   <= out_pc_d;
      raw_q      <= raw_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and next-PC mux; redirect outranks both bus response and stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    out_pc_d   = out_pc_q;
    raw_d      = raw_q;
    misalign_d = misalign_q;
    unique case (state_q)
      FC_REQ: begin
        if (redirect_valid) begin
          if (pc_misaligned || iresp_data_ok) begin
            pc_d = redirect_pc;
          end else begin
            pend_pc_d = redirect_pc;
            state_d   = FC_DRAIN;
          end
        end else if (pc_misaligned) begin
          raw_d      = 32'd0;
          out_pc_d   = pc_q;
          misalign_d = 1'b1;
          state_d    = FC_VALID;
        end else if (iresp_data_ok) begin
          raw_d      = iresp_data;
          out_pc_d   = pc_q;
          misalign_d = 1'b0;
          state_d    = FC_VALID;
        end
      end
      FC_VALID: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FC_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 64'(PC_STEP);
          state_d = FC_REQ;
        end
      end
      FC_DRAIN: begin
        // The abandoned response is swallowed here; a redirect in the same cycle still wins.
        if (iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
          state_d = FC_REQ;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
      end
      default: state_d = FC_REQ;
    endcase
  end

  // Output decode from state; the bus is quiet while reset is held.
  always_comb begin
    ireq_valid  = 1'b0;
    ivalid      = 1'b0;
    instr_fetch = INSTR_CONTINUE;
    unique case (state_q)
      FC_REQ:   ireq_valid = reset & ~pc_misaligned;
      FC_VALID: begin
        ivalid = 1'b1;
        if (stall && !redirect_valid) instr_fetch = INSTR_MAINTAIN;
      end
      FC_DRAIN: ireq_valid = reset;
      default: ;
    endcase
  end

  assign ireq_addr = pc_q;
  assign iwait     = ireq_valid & ~iresp_data_ok;
  assign raw_instr = raw_q;
  assign pc        = out_pc_q;
  assign misalign  = ivalid & misalign_q;

endmodule
